idecode_sb: RTL and testbench
=============================

# idecode_sb

Parametrised decode/register-file stage for the single-cycle-to-pipelined CPU migration. It holds the general-purpose register file and selects the destination register (rt / rd / link). It sign- or zero-extends the immediate and captures operands into a registered ID/EX stage with a valid/ready handshake. A per-register scoreboard tracks writes still in flight (loads, multi-cycle ALU ops) and stalls issue on RAW/WAW hazards, with same-cycle write-back bypass into the operand read.

## Interface
Parameters:
- DATA_W, 32, register and operand width (>=16)
- AW, 5, register address width (1..5); NREGS = 2**AW; instruction fields use their low AW bits
- LINK_REG, 2**AW-1, destination index for JAL

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  instruction present in decode
- id_ready  out  1  decode accepts instruction this cycle
- instruction  in  32  rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]
- jal  in  1  destination is LINK_REG, write data is pc_plus4
- reg_write  in  1  instruction writes a register
- reg_dst  in  1  1: rd, 0: rt
- zext  in  1  1: zero-extend imm, 0: sign-extend
- pc_plus4  in  DATA_W  link value for JAL
- wb_en  in  1  write-back strobe
- wb_addr  in  AW  write-back register
- wb_data  in  DATA_W  write-back value
- ex_valid  out  1  ID/EX stage holds a valid instruction
- ex_ready  in  1  execute consumes ID/EX this cycle
- ex_rs_data, ex_rt_data  out  DATA_W  captured operands
- ex_imm  out  DATA_W  extended immediate
- ex_dest  out  AW  destination register
- ex_reg_write  out  1  registered reg_write (forced 0 when dest is r0)
- ex_link  out  DATA_W  registered pc_plus4 when jal, else 0

## Operation
- Register array: NREGS x DATA_W. r0 reads 0 and is never written.
- Write port: on wb_en with wb_addr != 0, regs[wb_addr] <= wb_data. Clear pending[wb_addr].
- Destination: jal ? LINK_REG : (reg_dst ? rd : rt).
- Operand read: regs[rs] / regs[rt], combinational. If wb_en && wb_addr == src && src != 0, wb_data is substituted (bypass).
- Immediate: zext ? {0, imm} : {DATA_W-16 copies of imm[15], imm}.
- Hazard: hz = (pending[rs] || pending[rt] || (reg_write && pending[dest])) after masking any index cleared by this cycle's write-back. Index 0 is never pending.
- id_ready = !hz && (!ex_valid || ex_ready).
- Issue fires when id_valid && id_ready:
  - ID/EX registers load.
  - ex_valid <= 1.
  - If reg_write && dest != 0, pending[dest] <= 1.
- Set/clear collision: set and clear of the same index in one cycle leaves it set (set wins).
- If ex_ready && no issue: ex_valid <= 0. ID/EX data holds its last value.
- If ex_valid && !ex_ready: all ex_* outputs hold.
- Write-back to a non-pending register: performed normally, no error.

## Timing
- Reset: all registers, all pending bits, ex_valid, and every ex_* output go to 0.
- id_ready is combinational from pending state, the write-back inputs, ex_valid and ex_ready. It has no dependency on id_valid.
- Decode-to-execute latency: 1 cycle. The instruction accepted at edge N appears on ex_* after edge N.
- Write-back visibility:
  - Same cycle via bypass for the operand read.
  - From the array after the edge.
- Throughput: 1 instruction/cycle with no hazards and ex_ready held high.
- Reset asserted mid-stall or mid-handshake: the next edge discards ID/EX and clears all pending bits, and id_ready returns to 1.

## Test plan
- Reset, then read r5 -> ex_rs_data = 0. ex_valid = 0 immediately after reset.
- Write-back r3 = 0x1234 with wb_en, and in the same cycle issue an instruction with rs = 3 -> ex_rs_data = 0x1234 one cycle later.
- Issue a load to r7 (reg_write, rt = 7), then an instruction with rs = 7 -> id_ready = 0 until wb_en to r7. Issue then occurs in the write-back cycle with bypassed data.
- imm = 0x8001 with zext = 0 -> ex_imm = 0xFFFF8001. With zext = 1 -> 0x00008001 (DATA_W = 32).
- JAL with pc_plus4 = 0x40 -> ex_dest = 31, ex_link = 0x40, pending[31] set. Write-back to r0 -> r0 still reads 0.
- Hold ex_ready = 0 with ex_valid = 1 -> id_ready = 0 and ex_* stable for 3 cycles. Raise ex_ready -> next instruction issues.

Source files
------------

// File: rtl/idecode_sb.sv
// Decode / register-file stage: GPR array, destination select, immediate
// extension, scoreboarded hazard stall and a registered ID/EX handshake stage.
module idecode_sb #(
   parameter int DATA_W   = 32,
   parameter int AW       = 5,
   parameter int LINK_REG = (2**AW) - 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [31:0]       instruction,
   input  logic              jal,
   input  logic              reg_write,
   input  logic              reg_dst,
   input  logic              zext,
   input  logic [DATA_W-1:0] pc_plus4,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [AW-1:0]     ex_dest,
   output logic              ex_reg_write,
   output logic [DATA_W-1:0] ex_link
);

   localparam int            NREGS    = 2**AW;
   localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
   localparam logic [AW-1:0] R0_IDX   = {AW{1'b0}};

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [NREGS-1:0]  pending_q, pending_d;

   logic              ex_valid_q, ex_valid_d;
   logic [DATA_W-1:0] ex_rs_q, ex_rs_d;
   logic [DATA_W-1:0] ex_rt_q, ex_rt_d;
   logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
   logic [AW-1:0]     ex_dest_q, ex_dest_d;
   logic              ex_rw_q, ex_rw_d;
   logic [DATA_W-1:0] ex_link_q, ex_link_d;

   logic [AW-1:0]     rs, rt, rd, dest;
   logic [15:0]       imm;
   logic              wb_write, hazard, issue, dest_writes;
   logic [NREGS-1:0]  wb_clr, set_vec, pend_live;
   logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
   logic              unused_instr_bits;

   assign rs  = instruction[21 +: AW];
   assign rt  = instruction[16 +: AW];
   assign rd  = instruction[11 +: AW];
   assign imm = instruction[15:0];
   assign unused_instr_bits = ^instruction;

   // Destination, write-back decode and scoreboard hazard evaluation
   always_comb begin
      dest        = jal ? LINK_IDX : (reg_dst ? rd : rt);
      wb_write    = wb_en && (wb_addr != R0_IDX);
      dest_writes = reg_write && (dest != R0_IDX);
      if (wb_write) begin
         wb_clr = {{(NREGS-1){1'b0}}, 1'b1} << wb_addr;
      end else begin
         wb_clr = {NREGS{1'b0}};
      end
      // a register being written back this cycle no longer blocks issue
      pend_live = pending_q & ~wb_clr;
      hazard    = pend_live[rs] || pend_live[rt] || (reg_write && pend_live[dest]);
      id_ready  = !hazard && (!ex_valid_q || ex_ready);
      issue     = id_valid && id_ready;
   end

   // Operand read with same-cycle write-back bypass; r0 is hard zero
   always_comb begin
      if (rs == R0_IDX) begin
         rs_val = {DATA_W{1'b0}};
      end else if (wb_en && (wb_addr == rs)) begin
         rs_val = wb_data;
      end else begin
         rs_val = regs_q[rs];
      end
      if (rt == R0_IDX) begin
         rt_val = {DATA_W{1'b0}};
      end else if (wb_en && (wb_addr == rt)) begin
         rt_val = wb_data;
      end else begin
         rt_val = regs_q[rt];
      end
      if (zext) begin
         imm_ext = {{(DATA_W-16){1'b0}}, imm};
      end else begin
         imm_ext = {{(DATA_W-16){imm[15]}}, imm};
      end
   end

   // Register array and scoreboard next state; set beats clear on collision
   always_comb begin
      regs_d = regs_q;
      if (wb_write) begin
         regs_d[wb_addr] = wb_data;
      end else begin
         regs_d[wb_addr] = regs_q[wb_addr];
      end
      if (issue && dest_writes) begin
         set_vec = {{(NREGS-1){1'b0}}, 1'b1} << dest;
      end else begin
         set_vec = {NREGS{1'b0}};
      end
      pending_d = (pending_q & ~wb_clr) | set_vec;
   end

   // ID/EX stage next state: load on issue, drop valid when consumed
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_rs_d    = ex_rs_q;
      ex_rt_d    = ex_rt_q;
      ex_imm_d   = ex_imm_q;
      ex_dest_d  = ex_dest_q;
      ex_rw_d    = ex_rw_q;
      ex_link_d  = ex_link_q;
      if (issue) begin
         ex_valid_d = 1'b1;
         ex_rs_d    = rs_val;
         ex_rt_d    = rt_val;
         ex_imm_d   = imm_ext;
         ex_dest_d  = dest;
         ex_rw_d    = dest_writes;
         ex_link_d  = jal ? pc_plus4 : {DATA_W{1'b0}};
      end else if (ex_ready) begin
         ex_valid_d = 1'b0;
      end else begin
         ex_valid_d = ex_valid_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
         pending_q  <= {NREGS{1'b0}};
         ex_valid_q <= 1'b0;
         ex_rs_q    <= {DATA_W{1'b0}};
         ex_rt_q    <= {DATA_W{1'b0}};
         ex_imm_q   <= {DATA_W{1'b0}};
         ex_dest_q  <= R0_IDX;
         ex_rw_q    <= 1'b0;
         ex_link_q  <= {DATA_W{1'b0}};
      end else begin
         regs_q     <= regs_d;
         pending_q  <= pending_d;
         ex_valid_q <= ex_valid_d;
         ex_rs_q    <= ex_rs_d;
         ex_rt_q    <= ex_rt_d;
         ex_imm_q   <= ex_imm_d;
         ex_dest_q  <= ex_dest_d;
         ex_rw_q    <= ex_rw_d;
         ex_link_q  <= ex_link_d;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign ex_rs_data   = ex_rs_q;
   assign ex_rt_data   = ex_rt_q;
   assign ex_imm       = ex_imm_q;
   assign ex_dest      = ex_dest_q;
   assign ex_reg_write = ex_rw_q;
   assign ex_link      = ex_link_q;

endmodule

// File: tb/tb_idecode_sb.sv
// Directed bench for idecode_sb: an abstract register/scoreboard model is
// compared every cycle, plus hand-computed literal expectations.
module tb_idecode_sb;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_valid, id_ready;
   logic [31:0] instruction;
   logic        jal, reg_write, reg_dst, zext;
   logic [31:0] pc_plus4;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_link;
   logic [4:0]  ex_dest;
   logic        ex_reg_write;

   int checks = 0;
   int errors = 0;

   idecode_sb dut (
      .clock(clock), .reset(reset),
      .id_valid(id_valid), .id_ready(id_ready),
      .instruction(instruction), .jal(jal), .reg_write(reg_write),
      .reg_dst(reg_dst), .zext(zext), .pc_plus4(pc_plus4),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_link(ex_link)
   );

   always #5 clock = ~clock;

   // abstract model: register contents, in-flight set, and the ID/EX slot
   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bit          m_exv, m_rw;
   logic [31:0] m_rs, m_rt, m_imm, m_link;
   int          m_dest;

   function automatic int f_rs();   return int'(instruction[25:21]); endfunction
   function automatic int f_rt();   return int'(instruction[20:16]); endfunction
   function automatic int f_dest();
      if (jal) return 31;
      else if (reg_dst) return int'(instruction[15:11]);
      else return int'(instruction[20:16]);
   endfunction

   function automatic bit m_busy(int i);
      return (i != 0) && m_pend[i] && !(wb_en && int'(wb_addr) == i);
   endfunction

   function automatic bit m_ready();
      bit hz = m_busy(f_rs()) || m_busy(f_rt()) || (reg_write && m_busy(f_dest()));
      return !hz && (!m_exv || ex_ready);
   endfunction

   function automatic logic [31:0] m_read(int i);
      if (i == 0) return 32'd0;
      else if (wb_en && int'(wb_addr) == i) return wb_data;
      else return m_regs[i];
   endfunction

   function automatic logic [31:0] m_ext();
      int unsigned v = int'(instruction[15:0]);
      if (!zext && v >= 32768) v = v + 32'hFFFF_0000;
      return 32'(v);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_pend[i] = 1'b0; end
      m_exv = 1'b0; m_rw = 1'b0; m_dest = 0;
      m_rs = 32'd0; m_rt = 32'd0; m_imm = 32'd0; m_link = 32'd0;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_i(int s, int t, logic [15:0] im);
      return {6'd0, 5'(s), 5'(t), im};
   endfunction
   function automatic logic [31:0] mk_r(int s, int t, int d);
      return {6'd0, 5'(s), 5'(t), 5'(d), 11'd0};
   endfunction

   task automatic drv(bit v, logic [31:0] ins, bit rw, bit dst, bit zx, bit j,
                      logic [31:0] pc, bit we, int wa, logic [31:0] wd);
      id_valid = v; instruction = ins; reg_write = rw; reg_dst = dst;
      zext = zx; jal = j; pc_plus4 = pc;
      wb_en = we; wb_addr = 5'(wa); wb_data = wd;
   endtask

   // one cycle: compare DUT against model, then advance the model at the edge
   task automatic step();
      bit r, issue;
      logic [31:0] rsv, rtv;
      int d;
      #1;
      r = m_ready();
      chk("id_ready", id_ready, r);
      chk("ex_valid", ex_valid, m_exv);
      chk("ex_rs_data", ex_rs_data, m_rs);
      chk("ex_rt_data", ex_rt_data, m_rt);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_dest", ex_dest, m_dest);
      chk("ex_reg_write", ex_reg_write, m_rw);
      chk("ex_link", ex_link, m_link);
      @(posedge clock);
      if (reset) begin
         m_reset();
      end else begin
         issue = id_valid && r;
         rsv = m_read(f_rs()); rtv = m_read(f_rt()); d = f_dest();
         if (wb_en && wb_addr != 5'd0) begin
            m_regs[wb_addr] = wb_data; m_pend[wb_addr] = 1'b0;
         end
         if (issue) begin
            m_exv = 1'b1; m_rs = rsv; m_rt = rtv; m_imm = m_ext();
            m_dest = d; m_rw = reg_write && (d != 0);
            m_link = jal ? pc_plus4 : 32'd0;
            if (m_rw) m_pend[d] = 1'b1;
         end else if (ex_ready) begin
            m_exv = 1'b0;
         end
      end
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; ex_ready = 1'b1;
      drv(0, 32'd0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
      repeat (2) @(posedge clock);
      m_reset();
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("reset_ex_valid", ex_valid, 32'd0);
      chk("reset_id_ready", id_ready, 32'd1);

      // read r5 after reset
      drv(1, mk_i(5, 0, 16'h0), 0, 0, 0, 0, 32'd0, 0, 0, 32'd0); step();
      chk("r5_zero", ex_rs_data, 32'd0);
      chk("issue_valid", ex_valid, 32'd1);

      // write-back bypass into same-cycle issue
      drv(1, mk_i(3, 0, 16'h0), 0, 0, 0, 0, 32'd0, 1, 3, 32'h1234); step();
      chk("bypass_r3", ex_rs_data, 32'h1234);

      // load to r7, dependent read stalls until write-back
      drv(1, mk_i(0, 7, 16'h0010), 1, 0, 0, 0, 32'd0, 0, 0, 32'd0); step();
      chk("load_dest", ex_dest, 32'd7);
      drv(1, mk_i(7, 0, 16'h0), 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
      for (int k = 0; k < 2; k++) begin
         #1; chk("raw_stall", id_ready, 32'd0); step();
      end
      chk("stall_drains_ex", ex_valid, 32'd0);
      drv(1, mk_i(7, 0, 16'h0), 0, 0, 0, 0, 32'd0, 1, 7, 32'hCAFE0007);
      #1; chk("raw_release", id_ready, 32'd1); step();
      chk("raw_bypass", ex_rs_data, 32'hCAFE0007);

      // immediate extension
      drv(1, mk_i(0, 0, 16'h8001), 0, 0, 0, 0, 32'd0, 0, 0, 32'd0); step();
      chk("imm_sext", ex_imm, 32'hFFFF8001);
      drv(1, mk_i(0, 0, 16'h8001), 0, 0, 1, 0, 32'd0, 0, 0, 32'd0); step();
      chk("imm_zext", ex_imm, 32'h00008001);

      // JAL to link register, then consumer of r31 stalls until write-back
      drv(1, mk_r(0, 2, 4), 1, 1, 0, 1, 32'h40, 0, 0, 32'd0); step();
      chk("jal_dest", ex_dest, 32'd31);
      chk("jal_link", ex_link, 32'h40);
      chk("jal_rw", ex_reg_write, 32'd1);
      drv(1, mk_i(31, 0, 16'h0), 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
      #1; chk("r31_pending", id_ready, 32'd0); step();
      drv(1, mk_i(31, 0, 16'h0), 0, 0, 0, 0, 32'd0, 1, 31, 32'h5555); step();
      chk("r31_bypass", ex_rs_data, 32'h5555);

      // r0 is never written nor bypassed
      drv(1, mk_i(0, 0, 16'h0), 0, 0, 0, 0, 32'd0, 1, 0, 32'hDEAD); step();
      chk("r0_no_bypass", ex_rs_data, 32'd0);
      drv(1, mk_i(0, 0, 16'h0), 0, 0, 0, 0, 32'd0, 0, 0, 32'd0); step();
      chk("r0_reads_zero", ex_rs_data, 32'd0);

      // WAW stall, and pending dest ignored when not writing
      drv(1, mk_i(0, 9, 16'h0), 1, 0, 0, 0, 32'd0, 0, 0, 32'd0); step();
      drv(1, mk_r(1, 2, 9), 1, 1, 0, 0, 32'd0, 0, 0, 32'd0);
      #1; chk("waw_stall", id_ready, 32'd0); step();
      drv(1, mk_r(1, 2, 9), 0, 1, 0, 0, 32'd0, 0, 0, 32'd0); step();
      // set wins over a same-cycle clear of r9
      drv(1, mk_i(0, 9, 16'h0), 1, 0, 0, 0, 32'd0, 1, 9, 32'h99); step();
      drv(1, mk_i(9, 0, 16'h0), 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
      #1; chk("set_wins", id_ready, 32'd0); step();
      drv(1, mk_i(9, 0, 16'h0), 0, 0, 0, 0, 32'd0, 1, 9, 32'h77); step();

      // execute back-pressure holds the stage
      drv(1, mk_i(4, 5, 16'h1111), 0, 0, 0, 0, 32'd0, 0, 0, 32'd0); step();
      ex_ready = 1'b0;
      drv(1, mk_i(6, 0, 16'h2222), 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
      for (int k = 0; k < 3; k++) begin
         #1; chk("hold_ready", id_ready, 32'd0); step();
         chk("hold_imm", ex_imm, 32'h00001111);
      end
      ex_ready = 1'b1; step();
      chk("release_imm", ex_imm, 32'h00002222);

      // reset during a stall clears scoreboard and registers
      drv(1, mk_i(0, 12, 16'h0), 1, 0, 0, 0, 32'd0, 0, 0, 32'd0); step();
      drv(1, mk_i(12, 0, 16'h0), 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
      ex_ready = 1'b0; reset = 1'b1; step();
      reset = 1'b0; ex_ready = 1'b1;
      #1; chk("post_reset_ready", id_ready, 32'd1);
      chk("post_reset_valid", ex_valid, 32'd0);
      drv(1, mk_i(3, 0, 16'h0), 0, 0, 0, 0, 32'd0, 0, 0, 32'd0); step();
      chk("post_reset_r3", ex_rs_data, 32'd0);

      // write to r0 marks nothing
      drv(1, mk_i(0, 0, 16'h0), 1, 0, 0, 0, 32'd0, 0, 0, 32'd0); step();
      chk("r0_dest_rw", ex_reg_write, 32'd0);

      // back-to-back issue with write-backs feeding operands
      for (int k = 1; k < 9; k++) begin
         drv(1, mk_r(k, k - 1, 0), 0, 0, 0, 0, 32'd0, 1, k, 32'h01010101 * k);
         step();
      end
      chk("stream_rs", ex_rs_data, 32'h08080808);
      chk("stream_rt", ex_rt_data, 32'h07070707);

      drv(0, 32'd0, 0, 0, 0, 0, 32'd0, 0, 0, 32'd0);
      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
